// File: rtl/eth_llc_pkg.sv
// Shared definitions for the LLC receive demux.
// Header layout, broadcast address and parser states.
package eth_llc_pkg;

    localparam logic [3:0] DA_OFS  = 4'd0;
    localparam logic [3:0] SA_OFS  = 4'd6;
    localparam logic [3:0] TID_OFS = 4'd14;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        HDR,
        PAY,
        DROP
    } state_e;

endpackage

// File: rtl/eth_llc_pkt_fifo.sv
// Per-channel packet FIFO with speculative write, commit and rollback.
// Reader only sees committed bytes; bit 8 of each entry carries tlast.
module eth_llc_pkt_fifo #(
    parameter int DEPTH = 4096
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wr_en_i,
    input  logic [8:0] wr_data_i,
    input  logic       commit_i,
    input  logic       rollback_i,
    output logic       full_o,
    output logic       m_tvalid_o,
    input  logic       m_tready_i,
    output logic [8:0] m_tdata_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [8:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] cwptr_q, cwptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          vld_q, vld_d;
    logic [8:0]    dat_q, dat_d;
    logic          rd_en;

    assign full_o     = (wptr_q - rptr_q) == PW'(DEPTH);
    assign rd_en      = (rptr_q != cwptr_q) && (!vld_q || m_tready_i);
    assign m_tvalid_o = vld_q;
    assign m_tdata_o  = dat_q;

    // Pointer updates and output register refill.
    always_comb begin
        wptr_d  = wptr_q;
        cwptr_d = cwptr_q;
        rptr_d  = rptr_q;
        vld_d   = vld_q;
        dat_d   = dat_q;
        if (rollback_i) begin
            wptr_d = cwptr_q;
        end else if (wr_en_i) begin
            wptr_d = wptr_q + 1'b1;
            if (commit_i) begin
                cwptr_d = wptr_q + 1'b1;
            end
        end
        if (rd_en) begin
            rptr_d = rptr_q + 1'b1;
            vld_d  = 1'b1;
            dat_d  = mem_q[rptr_q[AW-1:0]];
        end else if (m_tready_i) begin
            vld_d = 1'b0;
        end
    end

    // Storage array, written at the speculative pointer.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !rollback_i) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Pointer and output stage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            cwptr_q <= '0;
            rptr_q  <= '0;
            vld_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            cwptr_q <= cwptr_d;
            rptr_q  <= rptr_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
        end
    end

endmodule

// File: rtl/eth_llc_rx_demux.sv
// Store-and-forward LLC receive demux: header parse, DA filter,
// per-channel packet FIFOs with commit/rollback, drop statistics.
module eth_llc_rx_demux
    import eth_llc_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          DEPTH     = 4096,
    parameter logic [47:0] LOCAL_MAC = 48'h0,
    parameter bit          FILTER_EN = 1'b1,
    parameter int          CNT_W     = 16
) (
    input  logic                    clki,
    input  logic                    rsti_n,
    input  logic                    s_axis_tvalid_mac,
    input  logic                    s_axis_tlast_mac,
    input  logic [7:0]              s_axis_tdata_mac,
    output logic [NUM_CH-1:0]       m_axis_tvalid,
    input  logic [NUM_CH-1:0]       m_axis_tready,
    output logic [NUM_CH-1:0]       m_axis_tlast,
    output logic [NUM_CH*8-1:0]     m_axis_tdata,
    output logic                    remote_mac_en_o,
    output logic [47:0]             remote_mac_o,
    output logic [NUM_CH*CNT_W-1:0] ovf_cnt_o,
    output logic [CNT_W-1:0]        bad_cnt_o
);

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         ch_q, ch_d;
    logic [47:0]        da_q, da_d;
    logic [47:0]        sa_q, sa_d;
    logic [47:0]        rmac_q, rmac_d;
    logic               rmac_en_q, rmac_en_d;
    logic [CNT_W-1:0]   bad_q, bad_d;
    logic [CNT_W-1:0]   ovf_q [NUM_CH];
    logic [CNT_W-1:0]   ovf_d [NUM_CH];
    logic [NUM_CH-1:0]  wr_en, commit, rollback, full;
    logic [8:0]         wr_data;
    logic [8:0]         dout [NUM_CH];
    logic               sel_full;
    logic               da_ok;
    logic               tid_ok;
    logic [3:0]         da_pos;

    assign wr_data = {s_axis_tlast_mac, s_axis_tdata_mac};
    assign da_pos  = idx_q - DA_OFS;
    assign da_ok   = !FILTER_EN || (da_q == LOCAL_MAC) || (da_q == BCAST_MAC);
    assign tid_ok  = {1'b0, s_axis_tdata_mac} < 9'(NUM_CH);

    // Full flag of the channel currently being written.
    always_comb begin
        sel_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == 4'(i)) begin
                sel_full = full[i];
            end
        end
    end

    // Parser next state, FIFO strobes and saturating counters.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ch_d      = ch_q;
        da_d      = da_q;
        sa_d      = sa_q;
        rmac_d    = rmac_q;
        rmac_en_d = 1'b0;
        bad_d     = bad_q;
        ovf_d     = ovf_q;
        wr_en     = '0;
        commit    = '0;
        rollback  = '0;
        if (s_axis_tvalid_mac) begin
            unique case (state_q)
                HDR: begin
                    if (s_axis_tlast_mac) begin
                        idx_d = 4'd0;
                        bad_d = bad_q + {{(CNT_W-1){1'b0}}, ~&bad_q};
                    end else if (idx_q == TID_OFS) begin
                        idx_d = 4'd0;
                        if (da_ok && tid_ok) begin
                            ch_d    = s_axis_tdata_mac[3:0];
                            state_d = PAY;
                        end else begin
                            state_d = DROP;
                            bad_d   = bad_q + {{(CNT_W-1){1'b0}}, ~&bad_q};
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (da_pos < (SA_OFS - DA_OFS)) begin
                            da_d = {da_q[39:0], s_axis_tdata_mac};
                        end else if (idx_q < SA_OFS + 4'd6) begin
                            sa_d = {sa_q[39:0], s_axis_tdata_mac};
                        end
                    end
                end
                PAY: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_q == 4'(i)) begin
                            if (full[i]) begin
                                rollback[i] = 1'b1;
                                ovf_d[i]    = ovf_q[i] +
                                    {{(CNT_W-1){1'b0}}, ~&ovf_q[i]};
                            end else begin
                                wr_en[i]  = 1'b1;
                                commit[i] = s_axis_tlast_mac;
                            end
                        end
                    end
                    if (sel_full) begin
                        state_d = s_axis_tlast_mac ? HDR : DROP;
                    end else if (s_axis_tlast_mac) begin
                        state_d   = HDR;
                        rmac_d    = sa_q;
                        rmac_en_d = 1'b1;
                    end
                end
                DROP: begin
                    if (s_axis_tlast_mac) begin
                        state_d = HDR;
                        idx_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = HDR;
                    idx_d   = 4'd0;
                end
            endcase
        end
    end

    // Parser and statistics registers.
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            state_q   <= HDR;
            idx_q     <= '0;
            ch_q      <= '0;
            da_q      <= '0;
            sa_q      <= '0;
            rmac_q    <= '0;
            rmac_en_q <= 1'b0;
            bad_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ovf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ch_q      <= ch_d;
            da_q      <= da_d;
            sa_q      <= sa_d;
            rmac_q    <= rmac_d;
            rmac_en_q <= rmac_en_d;
            bad_q     <= bad_d;
            ovf_q     <= ovf_d;
        end
    end

    assign remote_mac_en_o = rmac_en_q;
    assign remote_mac_o    = rmac_q;
    assign bad_cnt_o       = bad_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        eth_llc_pkt_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i      (clki),
            .rst_ni     (rsti_n),
            .wr_en_i    (wr_en[g]),
            .wr_data_i  (wr_data),
            .commit_i   (commit[g]),
            .rollback_i (rollback[g]),
            .full_o     (full[g]),
            .m_tvalid_o (m_axis_tvalid[g]),
            .m_tready_i (m_axis_tready[g]),
            .m_tdata_o  (dout[g])
        );
        assign m_axis_tlast[g]          = dout[g][8];
        assign m_axis_tdata[8*g+:8]     = dout[g][7:0];
        assign ovf_cnt_o[CNT_W*g+:CNT_W] = ovf_q[g];
    end

endmodule

// File: tb/tb_eth_llc_rx_demux.sv
// Directed testbench for eth_llc_rx_demux.
// Frames are driven on the MAC side; per-channel output bytes are collected.
module tb_eth_llc_rx_demux;

    localparam int          NCH   = 4;
    localparam int          DEPTH = 64;
    localparam int          CNT_W = 16;
    localparam logic [47:0] LMAC  = 48'h0200_0000_0001;
    localparam logic [47:0] BMAC  = 48'hFFFF_FFFF_FFFF;

    logic                  clki = 1'b0;
    logic                  rsti_n = 1'b0;
    logic                  s_axis_tvalid_mac = 1'b0;
    logic                  s_axis_tlast_mac = 1'b0;
    logic [7:0]            s_axis_tdata_mac = 8'h00;
    logic [NCH-1:0]        m_axis_tvalid;
    logic [NCH-1:0]        m_axis_tready = '1;
    logic [NCH-1:0]        m_axis_tlast;
    logic [NCH*8-1:0]      m_axis_tdata;
    logic                  remote_mac_en_o;
    logic [47:0]           remote_mac_o;
    logic [NCH*CNT_W-1:0]  ovf_cnt_o;
    logic [CNT_W-1:0]      bad_cnt_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [8:0] rxq [NCH][$];
    logic [8:0] exq [NCH][$];

    always #5 clki = ~clki;

    eth_llc_rx_demux #(
        .NUM_CH    (NCH),
        .DEPTH     (DEPTH),
        .LOCAL_MAC (LMAC),
        .FILTER_EN (1'b1),
        .CNT_W     (CNT_W)
    ) dut (
        .clki              (clki),
        .rsti_n            (rsti_n),
        .s_axis_tvalid_mac (s_axis_tvalid_mac),
        .s_axis_tlast_mac  (s_axis_tlast_mac),
        .s_axis_tdata_mac  (s_axis_tdata_mac),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tdata      (m_axis_tdata),
        .remote_mac_en_o   (remote_mac_en_o),
        .remote_mac_o      (remote_mac_o),
        .ovf_cnt_o         (ovf_cnt_o),
        .bad_cnt_o         (bad_cnt_o)
    );

    always @(negedge clki) begin
        for (int i = 0; i < NCH; i++) begin
            if (m_axis_tvalid[i] && m_axis_tready[i]) begin
                rxq[i].push_back({m_axis_tlast[i], m_axis_tdata[8*i+:8]});
            end
        end
        if (remote_mac_en_o) pulses++;
    end

    task automatic beat(input logic [7:0] d, input logic last);
        @(posedge clki);
        #1;
        s_axis_tvalid_mac = 1'b1;
        s_axis_tdata_mac  = d;
        s_axis_tlast_mac  = last;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clki);
            #1;
            s_axis_tvalid_mac = 1'b0;
            s_axis_tlast_mac  = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [47:0] da, input logic [47:0] sa,
                              input logic [7:0] tid, input int plen,
                              input logic [7:0] base, input int abort_at);
        int total;
        logic [7:0] b;
        total = 15 + plen;
        for (int k = 0; k < total; k++) begin
            if (abort_at != 0 && k == abort_at) break;
            if (k < 6) b = da[47-8*k-:8];
            else if (k < 12) b = sa[47-8*(k-6)-:8];
            else if (k < 14) b = 8'h00;
            else if (k == 14) b = tid;
            else b = 8'(base + 8'(k - 15));
            beat(b, k == total - 1);
        end
    endtask

    task automatic send_runt(input int n);
        for (int k = 0; k < n; k++) begin
            beat(8'(k), k == n - 1);
        end
    endtask

    task automatic clear_q();
        for (int i = 0; i < NCH; i++) rxq[i].delete();
    endtask

    task automatic test_reset();
        rsti_n = 1'b0;
        m_axis_tready = '1;
        repeat (3) @(posedge clki);
        #1;
        checks++;
        if (m_axis_tvalid !== 4'b0) begin
            errors++;
            $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid);
        end
        checks++;
        if (m_axis_tdata !== 32'h0 || m_axis_tlast !== 4'b0) begin
            errors++;
            $display("FAIL reset_tdata got %h/%b want 0", m_axis_tdata, m_axis_tlast);
        end
        checks++;
        if (remote_mac_en_o !== 1'b0 || remote_mac_o !== 48'h0) begin
            errors++;
            $display("FAIL reset_rmac got %b/%h want 0", remote_mac_en_o, remote_mac_o);
        end
        checks++;
        if (bad_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_bad got %0d want 0", bad_cnt_o);
        end
        checks++;
        if (ovf_cnt_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_ovf got %h want 0", ovf_cnt_o);
        end
        @(posedge clki);
        #1;
        rsti_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        clear_q();
        pulses = 0;
        send_frame(LMAC, 48'h0A0B_0C0D_0E0F, 8'd2, 64, 8'h00, 0);
        idle(1);
        checks++;
        if (m_axis_tvalid[2] !== 1'b0) begin
            errors++;
            $display("FAIL basic_lat1 got %b want 0", m_axis_tvalid[2]);
        end
        @(posedge clki);
        #1;
        checks++;
        if (m_axis_tvalid[2] !== 1'b1) begin
            errors++;
            $display("FAIL basic_lat2 got %b want 1", m_axis_tvalid[2]);
        end
        idle(80);
        checks++;
        if (rxq[2].size() != 64) begin
            errors++;
            $display("FAIL basic_len got %0d want 64", rxq[2].size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (rxq[2][i] !== {i == 63, 8'(i)}) begin
                    errors++;
                    $display("FAIL basic_byte%0d got %h want %h",
                             i, rxq[2][i], {i == 63, 8'(i)});
                end
            end
        end
        checks++;
        if (rxq[0].size() + rxq[1].size() + rxq[3].size() != 0) begin
            errors++;
            $display("FAIL basic_idle got %0d bytes want 0",
                     rxq[0].size() + rxq[1].size() + rxq[3].size());
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL basic_pulse got %0d want 1", pulses);
        end
        checks++;
        if (remote_mac_o !== 48'h0A0B_0C0D_0E0F) begin
            errors++;
            $display("FAIL basic_rmac got %h want 0a0b0c0d0e0f", remote_mac_o);
        end
    endtask

    task automatic test_filter();
        clear_q();
        pulses = 0;
        send_frame(BMAC, 48'h1111_2222_3333, 8'd0, 10, 8'h10, 0);
        send_frame(48'h1234_5678_9ABC, 48'h4444_5555_6666, 8'd0, 10, 8'h20, 0);
        idle(40);
        checks++;
        if (rxq[0].size() != 10) begin
            errors++;
            $display("FAIL filter_len got %0d want 10", rxq[0].size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rxq[0][i] !== {i == 9, 8'(8'h10 + i)}) begin
                    errors++;
                    $display("FAIL filter_byte%0d got %h want %h",
                             i, rxq[0][i], {i == 9, 8'(8'h10 + i)});
                end
            end
        end
        checks++;
        if (bad_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL filter_bad got %0d want 1", bad_cnt_o);
        end
        checks++;
        if (pulses != 1 || remote_mac_o !== 48'h1111_2222_3333) begin
            errors++;
            $display("FAIL filter_rmac got %0d/%h want 1/111122223333",
                     pulses, remote_mac_o);
        end
    endtask

    task automatic test_bad_frames();
        clear_q();
        pulses = 0;
        send_frame(LMAC, 48'h7777_7777_7777, 8'd7, 10, 8'h30, 0);
        send_runt(8);
        idle(30);
        checks++;
        if (rxq[0].size() + rxq[1].size() + rxq[2].size() + rxq[3].size() != 0) begin
            errors++;
            $display("FAIL bad_nodata got %0d bytes want 0",
                     rxq[0].size() + rxq[1].size() + rxq[2].size() + rxq[3].size());
        end
        checks++;
        if (bad_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL bad_cnt got %0d want 3", bad_cnt_o);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL bad_pulse got %0d want 0", pulses);
        end
        send_frame(LMAC, 48'h8888_8888_8888, 8'd3, 12, 8'h40, 0);
        idle(40);
        checks++;
        if (rxq[3].size() != 12) begin
            errors++;
            $display("FAIL bad_next_len got %0d want 12", rxq[3].size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (rxq[3][i] !== {i == 11, 8'(8'h40 + i)}) begin
                    errors++;
                    $display("FAIL bad_next_byte%0d got %h want %h",
                             i, rxq[3][i], {i == 11, 8'(8'h40 + i)});
                end
            end
        end
    endtask

    task automatic test_overflow();
        clear_q();
        m_axis_tready = 4'b1101;
        send_frame(LMAC, 48'h9999_0000_0001, 8'd1, 40, 8'h00, 0);
        send_frame(LMAC, 48'h9999_0000_0002, 8'd1, 40, 8'h80, 0);
        idle(10);
        checks++;
        if (ovf_cnt_o !== 64'h0000_0000_0001_0000) begin
            errors++;
            $display("FAIL ovf_cnt got %h want 0000000000010000", ovf_cnt_o);
        end
        checks++;
        if (rxq[1].size() != 0) begin
            errors++;
            $display("FAIL ovf_held got %0d want 0", rxq[1].size());
        end
        checks++;
        if (remote_mac_o !== 48'h9999_0000_0001) begin
            errors++;
            $display("FAIL ovf_rmac got %h want 999900000001", remote_mac_o);
        end
        m_axis_tready = '1;
        idle(80);
        checks++;
        if (rxq[1].size() != 40) begin
            errors++;
            $display("FAIL ovf_len got %0d want 40", rxq[1].size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                checks++;
                if (rxq[1][i] !== {i == 39, 8'(i)}) begin
                    errors++;
                    $display("FAIL ovf_byte%0d got %h want %h",
                             i, rxq[1][i], {i == 39, 8'(i)});
                end
            end
        end
        clear_q();
        send_frame(LMAC, 48'h9999_0000_0003, 8'd1, 20, 8'hC0, 0);
        idle(50);
        checks++;
        if (rxq[1].size() != 20) begin
            errors++;
            $display("FAIL ovf_after_len got %0d want 20", rxq[1].size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (rxq[1][i] !== {i == 19, 8'(8'hC0 + i)}) begin
                    errors++;
                    $display("FAIL ovf_after_byte%0d got %h want %h",
                             i, rxq[1][i], {i == 19, 8'(8'hC0 + i)});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit done;
        int plen;
        logic [7:0] base;
        clear_q();
        for (int i = 0; i < NCH; i++) exq[i].delete();
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    plen = 5 + (k * 3) % 17;
                    base = 8'(k * 20);
                    for (int j = 0; j < plen; j++) begin
                        exq[k % 4].push_back({j == plen - 1, 8'(base + 8'(j))});
                    end
                    send_frame(LMAC, 48'hA000_0000_0000 + 48'(k),
                               8'(k % 4), plen, base, 0);
                end
                idle(1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clki);
                    #1;
                    m_axis_tready = 4'($urandom);
                end
            end
        join
        m_axis_tready = '1;
        idle(200);
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (rxq[c].size() != exq[c].size()) begin
                errors++;
                $display("FAIL b2b_len_ch%0d got %0d want %0d",
                         c, rxq[c].size(), exq[c].size());
            end else begin
                for (int i = 0; i < exq[c].size(); i++) begin
                    checks++;
                    if (rxq[c][i] !== exq[c][i]) begin
                        errors++;
                        $display("FAIL b2b_ch%0d_byte%0d got %h want %h",
                                 c, i, rxq[c][i], exq[c][i]);
                    end
                end
            end
        end
        checks++;
        if (remote_mac_o !== 48'hA000_0000_000B) begin
            errors++;
            $display("FAIL b2b_rmac got %h want a0000000000b", remote_mac_o);
        end
    endtask

    task automatic test_reset_mid();
        m_axis_tready = 4'b1110;
        send_frame(LMAC, 48'hB000_0000_0001, 8'd0, 8, 8'h70, 0);
        idle(4);
        checks++;
        if (m_axis_tvalid[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got %b want 1", m_axis_tvalid[0]);
        end
        send_frame(LMAC, 48'hB000_0000_0002, 8'd0, 30, 8'h90, 20);
        rsti_n = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_tvalid got %b want 0", m_axis_tvalid);
        end
        checks++;
        if (bad_cnt_o !== 16'h0 || ovf_cnt_o !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_cnt got %0d/%h want 0/0", bad_cnt_o, ovf_cnt_o);
        end
        checks++;
        if (remote_mac_o !== 48'h0) begin
            errors++;
            $display("FAIL rstmid_rmac got %h want 0", remote_mac_o);
        end
        s_axis_tvalid_mac = 1'b0;
        s_axis_tlast_mac  = 1'b0;
        @(posedge clki);
        #1;
        rsti_n = 1'b1;
        m_axis_tready = '1;
        clear_q();
        idle(2);
        send_frame(LMAC, 48'hB000_0000_0003, 8'd0, 16, 8'h55, 0);
        idle(40);
        checks++;
        if (rxq[0].size() != 16) begin
            errors++;
            $display("FAIL rstmid_len got %0d want 16", rxq[0].size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rxq[0][i] !== {i == 15, 8'(8'h55 + i)}) begin
                    errors++;
                    $display("FAIL rstmid_byte%0d got %h want %h",
                             i, rxq[0][i], {i == 15, 8'(8'h55 + i)});
                end
            end
        end
        checks++;
        if (rxq[1].size() + rxq[2].size() + rxq[3].size() != 0) begin
            errors++;
            $display("FAIL rstmid_other got %0d want 0",
                     rxq[1].size() + rxq[2].size() + rxq[3].size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_filter();
        test_bad_frames();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
